// File: rtl/v3_credit_sender.sv
// v3_credit_sender: credit-based producer front end for v3_SyncFifo.
// It turns a back-pressured val/rdy stream into single-cycle FIFO write
// pulses. It never writes while the downstream FIFO has no free slot.
// Optional feature macro: V3_CREDIT_SENDER_STALL_CNT_EN adds a saturating
// 16-bit stall counter on output stall_count.
module v3_credit_sender #(
    parameter int p_num_entries = 8,
    parameter int p_bit_width   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [p_bit_width-1:0]             istream_msg,
    input  logic                               istream_val,
    output logic                               istream_rdy,
    output logic [p_bit_width-1:0]             ostream_msg,
    output logic                               ostream_val,
    input  logic                               credit_return,
    output logic [$clog2(p_num_entries+1)-1:0] credits,
`ifdef V3_CREDIT_SENDER_STALL_CNT_EN
    output logic [15:0]                        stall_count,
`endif
    output logic                               overflow_err
);

    localparam int CW = $clog2(p_num_entries + 1);
    // Credit arithmetic uses one extra bit so that a return at full count
    // can be detected before it is saturated.
    localparam logic [CW-1:0] FULL_CR  = CW'(p_num_entries);
    localparam logic [CW:0]   FULL_EXT = (CW + 1)'(p_num_entries);

    logic [CW-1:0]          credits_q, credits_d;
    logic                   ovf_q, ovf_d;
    logic                   oval_q, oval_d;
    logic [p_bit_width-1:0] omsg_q, omsg_d;
    logic                   accept_s;
    logic [CW:0]            credits_ext_s;

    // Ready depends only on registered credit state.
    assign istream_rdy = (credits_q != {CW{1'b0}});
    assign accept_s    = istream_val & istream_rdy;

    assign credits_ext_s = {1'b0, credits_q}
                         - {{CW{1'b0}}, accept_s}
                         + {{CW{1'b0}}, credit_return};

    // Next-state for the credit counter and the sticky overflow flag.
    always_comb begin
        credits_d = credits_q;
        ovf_d     = ovf_q;
        if (credits_ext_s > FULL_EXT) begin
            // A credit came back while no slot was outstanding: saturate.
            credits_d = FULL_CR;
            ovf_d     = 1'b1;
        end else begin
            credits_d = credits_ext_s[CW-1:0];
            ovf_d     = ovf_q;
        end
    end

    // Next-state for the FIFO write pulse and its held data.
    always_comb begin
        oval_d = accept_s;
        omsg_d = omsg_q;
        if (accept_s) begin
            omsg_d = istream_msg;
        end else begin
            omsg_d = omsg_q;
        end
    end

    // State registers; reset drops any in-flight write pulse at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits_q <= FULL_CR;
            ovf_q     <= 1'b0;
            oval_q    <= 1'b0;
            omsg_q    <= {p_bit_width{1'b0}};
        end else begin
            credits_q <= credits_d;
            ovf_q     <= ovf_d;
            oval_q    <= oval_d;
            omsg_q    <= omsg_d;
        end
    end

    assign credits      = credits_q;
    assign overflow_err = ovf_q;
    assign ostream_val  = oval_q;
    assign ostream_msg  = omsg_q;

`ifdef V3_CREDIT_SENDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where upstream offers data but no credit is available.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (istream_val && !istream_rdy && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_v3_credit_sender.sv
// Directed testbench for v3_credit_sender (p_num_entries = 8, 32-bit data).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_v3_credit_sender;

    logic        clk;
    logic        reset;
    logic [31:0] istream_msg;
    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] ostream_msg;
    logic        ostream_val;
    logic        credit_return;
    logic [3:0]  credits;
    logic        overflow_err;
`ifdef V3_CREDIT_SENDER_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int checks_cnt;
    int fail_cnt;

    v3_credit_sender #(.p_num_entries(8), .p_bit_width(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .istream_msg  (istream_msg),
        .istream_val  (istream_val),
        .istream_rdy  (istream_rdy),
        .ostream_msg  (ostream_msg),
        .ostream_val  (ostream_val),
        .credit_return(credit_return),
        .credits      (credits),
`ifdef V3_CREDIT_SENDER_STALL_CNT_EN
        .stall_count  (stall_count),
`endif
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        istream_val   = 1'b0;
        istream_msg   = 32'd0;
        credit_return = 1'b0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;

        // Reset then idle
        do_reset();
        chk("rst_credits", 32'(credits), 32'd8);
        chk("rst_rdy", 32'(istream_rdy), 32'd1);
        chk("rst_oval", 32'(ostream_val), 32'd0);
        chk("rst_omsg", ostream_msg, 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);

        // Fill: 8 back-to-back accepts 0x10..0x17
        istream_val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            istream_msg = 32'h10 + 32'(i);
            chk("fill_rdy_before", 32'(istream_rdy), 32'd1);
            @(negedge clk);
            chk("fill_oval", 32'(ostream_val), 32'd1);
            chk("fill_omsg", ostream_msg, 32'h10 + 32'(i));
            chk("fill_credits", 32'(credits), 32'(7 - i));
        end
        chk("full_rdy", 32'(istream_rdy), 32'd0);
        // 9th message held upstream
        istream_msg = 32'h18;
        @(negedge clk);
        chk("held_oval", 32'(ostream_val), 32'd0);
        chk("held_omsg", ostream_msg, 32'h17);
        chk("held_credits", 32'(credits), 32'd0);
        chk("held_rdy", 32'(istream_rdy), 32'd0);

        // Refill: one credit return releases 0x18
        credit_return = 1'b1;
        @(negedge clk);
        credit_return = 1'b0;
        chk("refill_credits", 32'(credits), 32'd1);
        chk("refill_rdy", 32'(istream_rdy), 32'd1);
        chk("refill_oval_idle", 32'(ostream_val), 32'd0);
        @(negedge clk);
        istream_val = 1'b0;
        chk("refill_oval", 32'(ostream_val), 32'd1);
        chk("refill_omsg", ostream_msg, 32'h18);
        chk("refill_credits0", 32'(credits), 32'd0);

        // Return four credits
        credit_return = 1'b1;
        repeat (4) @(negedge clk);
        credit_return = 1'b0;
        chk("ret4_credits", 32'(credits), 32'd4);
        chk("ret4_oval", 32'(ostream_val), 32'd0);

        // Simultaneous accept and return at credits = 4
        istream_val   = 1'b1;
        istream_msg   = 32'h55;
        credit_return = 1'b1;
        @(negedge clk);
        istream_val   = 1'b0;
        credit_return = 1'b0;
        chk("simul_credits", 32'(credits), 32'd4);
        chk("simul_oval", 32'(ostream_val), 32'd1);
        chk("simul_omsg", ostream_msg, 32'h55);
        @(negedge clk);
        chk("simul_oval_single", 32'(ostream_val), 32'd0);
        chk("simul_omsg_hold", ostream_msg, 32'h55);
        chk("simul_credits_after", 32'(credits), 32'd4);

        // Return to full, then overflow
        credit_return = 1'b1;
        repeat (4) @(negedge clk);
        credit_return = 1'b0;
        chk("full_again_credits", 32'(credits), 32'd8);
        chk("full_again_ovf", 32'(overflow_err), 32'd0);
        credit_return = 1'b1;
        @(negedge clk);
        credit_return = 1'b0;
        chk("ovf_credits", 32'(credits), 32'd8);
        chk("ovf_set", 32'(overflow_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        chk("ovf_credits_hold", 32'(credits), 32'd8);

        // Asynchronous reset mid-stream drops an in-flight pulse
        istream_val = 1'b1;
        istream_msg = 32'h77;
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        chk("midrst_pulse_pre", 32'(ostream_val), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_oval", 32'(ostream_val), 32'd0);
        chk("midrst_omsg", ostream_msg, 32'd0);
        chk("midrst_credits", 32'(credits), 32'd8);
        chk("midrst_ovf", 32'(overflow_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("postrst_rdy", 32'(istream_rdy), 32'd1);

`ifdef V3_CREDIT_SENDER_STALL_CNT_EN
        // Stall counter: drain, then hold valid 5 cycles with no credit
        chk("stall_start", 32'(stall_count), 32'd0);
        istream_val = 1'b1;
        repeat (8) @(negedge clk);
        chk("stall_drained", 32'(credits), 32'd0);
        chk("stall_none_yet", 32'(stall_count), 32'd0);
        repeat (5) @(negedge clk);
        istream_val = 1'b0;
        chk("stall_five", 32'(stall_count), 32'd5);
        @(negedge clk);
        chk("stall_hold", 32'(stall_count), 32'd5);
        do_reset();
        chk("stall_reset", 32'(stall_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/v3_credit_sender.md
# v3_credit_sender

Producer-side front end for `v3_SyncFifo`, which has no full flag and no write backpressure. The block accepts an upstream val/rdy stream and issues single-cycle write pulses into the FIFO. It tracks free FIFO slots with a credit counter that is replenished by one-cycle credit-return pulses from the FIFO's consumer. It never issues a write while the FIFO is full, so it is the only legal way to drive a `v3_SyncFifo` write port from a back-pressured source.

## Interface
- `p_num_entries`, default 8, depth of the downstream FIFO and the initial credit count; must be a power of two ≥ 2.
- `p_bit_width`, default 32, message width.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset; asserting it (low) clears state immediately.
- `istream_msg`  in  `p_bit_width`  upstream message.
- `istream_val`  in  1  upstream valid.
- `istream_rdy`  out  1  upstream ready.
- `ostream_msg`  out  `p_bit_width`  FIFO write data; connects to FIFO `istream_msg`.
- `ostream_val`  out  1  FIFO write strobe; connects to FIFO `istream_val`.
- `credit_return`  in  1  one-cycle pulse per entry popped by the FIFO consumer (same signal as the FIFO's `ostream_rdy`).
- `credits`  out  `$clog2(p_num_entries+1)`  current free-slot count.
- `overflow_err`  out  1  sticky: a credit returned while the count was already full.

## Operation
- Accept condition: accept = `istream_val && istream_rdy`.
- Ready: `istream_rdy = (credits != 0)`.
  - Registered-state only; no combinational path from `credit_return` or `istream_val`.
- On accept:
  - Next cycle `ostream_val = 1` and `ostream_msg` = the accepted message.
  - Credits decrement by 1.
- Without an accept:
  - Next cycle `ostream_val = 0`.
  - `ostream_msg` holds its previous value.
- `ostream_val` is therefore high for exactly one cycle per accepted message. Back-to-back accepts give back-to-back pulses.
- Credit update: next `credits` = `credits` − accept + `credit_return`, computed in `$clog2(p_num_entries+1)+1` bits. Cases:
  - Accept and `credit_return` together: net 0; the count is unchanged.
  - `credits == 0` with `credit_return`: count goes to 1 next cycle, and `istream_rdy` rises that cycle.
  - `credits == p_num_entries`, `credit_return`, no accept: saturate at `p_num_entries` and set `overflow_err` = 1. It stays set until reset.
  - Accept cannot happen at `credits == 0`, so no underflow path exists.
- Reset asserted mid-stream:
  - All state returns to reset values immediately.
  - An in-flight `ostream_val` pulse is dropped.
  - The downstream FIFO must be reset in the same event.

## Timing
- Reset values:
  - `ostream_val` = 0
  - `ostream_msg` = 0
  - `credits` = `p_num_entries`
  - `overflow_err` = 0
  - `istream_rdy` = 1, from the cycle after reset deasserts
- Latency: accept in cycle N → FIFO write pulse in cycle N+1.
- Throughput: 1 message/cycle while credits remain.
- Credit loop: `credit_return` in cycle N → new credit visible on `credits`/`istream_rdy` in cycle N+1.
- Full drain: a burst of `p_num_entries` accepts with no returns takes `credits` to 0, and `istream_rdy` is low from the cycle after the last accept.

## Configuration
- `V3_CREDIT_SENDER_STALL_CNT_EN` defined:
  - Adds output `stall_count` (16 bits), reset to 0.
  - Increments on every cycle with `istream_val && !istream_rdy`.
  - Saturates at 16'hFFFF.
- Undefined: the `stall_count` port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset then idle: `reset` low 3 cycles, then high → `credits` = 8, `istream_rdy` = 1, `ostream_val` = 0, `ostream_msg` = 0, `overflow_err` = 0.
- Fill: 8 consecutive accepts of 0x10..0x17, no returns → `ostream_val` pulses in cycles 1–8 carrying 0x10..0x17; `credits` reaches 0; `istream_rdy` = 0; 9th message 0x18 held upstream.
- Refill: from the full state, one `credit_return` pulse → `credits` = 1, `istream_rdy` = 1 next cycle; 0x18 is accepted and emitted one cycle later; `credits` back to 0.
- Simultaneous accept + return at `credits` = 4 → `credits` stays 4; exactly one `ostream_val` pulse.
- Overflow: at `credits` = 8, pulse `credit_return` with no accept → `credits` stays 8; `overflow_err` = 1 and persists until reset.
- With `V3_CREDIT_SENDER_STALL_CNT_EN`: hold `istream_val` = 1 for 5 cycles at `credits` = 0 → `stall_count` = 5; reset → 0.
